// File: rtl/alu32_arbiter.sv
// alu32_arbiter
//   Shares one registered alu32 instance among NREQ requesters. A rotating
//   priority arbiter accepts one operation at a time. The sequencer drives the
//   ALU from latched operands and captures the one-cycle-latency result. It then
//   returns the result, plus a locally computed signed-overflow flag, on a
//   per-requester response channel.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready per-requester request handshake (req_ready one-hot)
//   req_a/req_b/req_sel packed per-requester operands and op codes
//   rsp_valid/rsp_ready per-requester response handshake (rsp_valid one-hot)
//   rsp_data/ovf/err    response payload
//   alu_a/alu_b/alu_sel ALU operand/select drive
//   alu_out             registered ALU result
module alu32_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ*4-1:0]    req_sel,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_ovf,
  output logic                 rsp_err,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_sel,
  input  logic [31:0]          alu_out
);

  localparam int unsigned NR = NREQ;
  localparam int unsigned PW = $clog2(NREQ);

  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   id_r;
  logic [31:0]     a_r;
  logic [31:0]     b_r;
  logic [3:0]      sel_r;

  logic            gnt_found;
  logic [PW-1:0]   gnt_id;
  logic [PW-1:0]   cand;
  logic [31:0]     g_a;
  logic [31:0]     g_b;
  logic [3:0]      g_sel;
  logic            hs;
  logic            g_legal;
  logic            ovf_calc;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base,
                                             input int unsigned off);
    return PW'((32'(base) + off) % NR);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] id);
    logic [NREQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Rotating priority: search starts just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      cand = wrap_idx(rr_ptr, k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  always_comb begin
    g_a   = '0;
    g_b   = '0;
    g_sel = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (gnt_id == PW'(i)) begin
        g_a   = req_a[32*i +: 32];
        g_b   = req_b[32*i +: 32];
        g_sel = req_sel[4*i +: 4];
      end
    end
  end

  assign req_ready = (rst_n && state == IDLE && gnt_found) ? onehot(gnt_id) : '0;
  assign hs        = |(req_valid & req_ready);
  assign g_legal   = (g_sel <= OP_SUB);

  always_comb begin
    ovf_calc = 1'b0;
    if (sel_r == OP_ADD)
      ovf_calc = (a_r[31] == b_r[31]) && (alu_out[31] != a_r[31]);
    else if (sel_r == OP_SUB)
      ovf_calc = (a_r[31] != b_r[31]) && (alu_out[31] != a_r[31]);
  end

  assign alu_a   = a_r;
  assign alu_b   = b_r;
  assign alu_sel = sel_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= PW'(NREQ - 1);
      id_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      sel_r     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_ovf   <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            id_r   <= gnt_id;
            rr_ptr <= gnt_id;
            if (g_legal) begin
              a_r   <= g_a;
              b_r   <= g_b;
              sel_r <= g_sel;
              state <= ISSUE;
            end else begin
              // Illegal ops never reach the ALU, so the operand registers keep
              // the previous op and the ALU drive does not move.
              rsp_data  <= '0;
              rsp_ovf   <= 1'b0;
              rsp_err   <= 1'b1;
              rsp_valid <= onehot(gnt_id);
              state     <= RESP;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          rsp_data  <= alu_out;
          rsp_ovf   <= ovf_calc;
          rsp_err   <= 1'b0;
          rsp_valid <= onehot(id_r);
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[id_r]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu32_arbiter.sv
module tb_alu32_arbiter;

  localparam int NREQ = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_a = '0;
  logic [NREQ*32-1:0]  req_b = '0;
  logic [NREQ*4-1:0]   req_sel = '0;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready = '1;
  logic [31:0]         rsp_data;
  logic                rsp_ovf;
  logic                rsp_err;
  logic [31:0]         alu_a;
  logic [31:0]         alu_b;
  logic [3:0]          alu_sel;
  logic [31:0]         alu_out = '0;

  int n_total = 0;
  int n_pass  = 0;

  alu32_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  // ---------------- stand-in for the alu32 instance ----------------
  function automatic logic [31:0] op_result(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] s);
    case (s)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a ^ b;
      4'd3: return a + b;
      4'd4: return a - b;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) alu_out <= op_result(alu_a, alu_b, alu_sel);

  // ---------------- behavioural model ----------------
  function automatic logic op_ovf(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] s);
    longint r;
    if (s == 4'd3)      r = longint'($signed(a)) + longint'($signed(b));
    else if (s == 4'd4) r = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (r > longint'(2147483647)) || (r < (-longint'(2147483647) - 1));
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int oh_to_int(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] sl_a(input int i);   return req_a[32*i +: 32]; endfunction
  function automatic logic [31:0] sl_b(input int i);   return req_b[32*i +: 32]; endfunction
  function automatic logic [3:0]  sl_sel(input int i); return req_sel[4*i +: 4]; endfunction

  logic        m_busy = 1'b0;
  int          m_id   = 0;
  int          m_ptr  = NREQ - 1;
  int          m_age  = 0;
  logic [31:0] m_oa   = '0;
  logic [31:0] m_ob   = '0;
  logic [3:0]  m_osel = '0;
  logic [31:0] m_la   = '0;
  logic [31:0] m_lb   = '0;
  logic [3:0]  m_lsel = '0;

  function automatic int m_pick();
    for (int k = 1; k <= NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    if (!rst_n || m_busy || m_pick() < 0) return '0;
    return oh(m_pick());
  endfunction

  // Response appears 1 cycle after grant for illegal ops, 3 for legal ones.
  function automatic logic [NREQ-1:0] exp_rv();
    if (m_busy && m_age >= ((m_osel > 4'd4) ? 1 : 3)) return oh(m_id);
    return '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_ptr  <= NREQ - 1;
      m_age  <= 0;
      m_la   <= '0;
      m_lb   <= '0;
      m_lsel <= '0;
    end else if (!m_busy) begin
      if (m_pick() >= 0) begin
        m_busy <= 1'b1;
        m_id   <= m_pick();
        m_ptr  <= m_pick();
        m_age  <= 1;
        m_oa   <= sl_a(m_pick());
        m_ob   <= sl_b(m_pick());
        m_osel <= sl_sel(m_pick());
        if (sl_sel(m_pick()) <= 4'd4) begin
          m_la   <= sl_a(m_pick());
          m_lb   <= sl_b(m_pick());
          m_lsel <= sl_sel(m_pick());
        end
      end
    end else begin
      if (exp_rv() != '0 && rsp_ready[m_id]) m_busy <= 1'b0;
      else m_age <= m_age + 1;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial forever begin
    @(negedge clk);
    check("mon_req_ready", 32'(req_ready), 32'(exp_ready()));
    check("mon_rsp_valid", 32'(rsp_valid), 32'(exp_rv()));
    check("mon_alu_a", alu_a, m_la);
    check("mon_alu_b", alu_b, m_lb);
    check("mon_alu_sel", 32'(alu_sel), 32'(m_lsel));
    if (exp_rv() != '0) begin
      check("mon_rsp_data", rsp_data, (m_osel > 4'd4) ? 32'd0 : op_result(m_oa, m_ob, m_osel));
      check("mon_rsp_ovf", 32'(rsp_ovf), (m_osel > 4'd4) ? 32'd0 : 32'(op_ovf(m_oa, m_ob, m_osel)));
      check("mon_rsp_err", 32'(rsp_err), 32'(m_osel > 4'd4));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_sel[4*id +: 4] = sel;
    req_valid[id]      = 1'b1;
  endtask

  // Wait (bounded) for the grant to id, then drop its request after the handshake edge.
  task automatic wait_grant(input int id);
    bit got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req_ready[id]) begin got = 1'b1; break; end
    end
    check($sformatf("grant%0d", id), 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp_done(input int id);
    bit got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid[id]) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check($sformatf("rsp%0d_seen", id), 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel, output logic [31:0] d, output logic o,
                        output logic e, output int lat);
    bit got = 1'b0;
    set_req(id, a, b, sel);
    wait_grant(id);
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin lat = c; got = 1'b1; break; end
    end
    check("op_rsp_seen", 32'(got), 32'd1);
    check("op_rsp_onehot", 32'(rsp_valid), 32'(oh(id)));
    d = rsp_data;
    o = rsp_ovf;
    e = rsp_err;
    @(posedge clk); #1;
  endtask

  // ---------------- directed tests ----------------
  logic [31:0] d;
  logic        o, e;
  int          lat;
  int          gid[5];
  int          gcyc[5];
  int          ng;

  initial begin
    // Reset state, with every requester asking.
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h1 + i, 32'h2, 4'd3);
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_ovf_err", {30'd0, rsp_ovf, rsp_err}, 32'd0);
    check("rst_alu", alu_a | alu_b | 32'(alu_sel), 32'd0);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: single ADD with cycle-exact timing.
    set_req(1, 32'd5, 32'd3, 4'd3);
    @(negedge clk);
    check("t1_ready_c0", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("t1_alu_sel_c1", 32'(alu_sel), 32'd3);
    @(negedge clk);
    check("t1_rsp_valid_c2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("t1_rsp_valid_c3", 32'(rsp_valid), 32'h2);
    check("t1_data", rsp_data, 32'd8);
    check("t1_ovf", 32'(rsp_ovf), 32'd0);
    @(posedge clk); #1;

    // 2: overflow boundaries.
    run_op(0, 32'h7FFF_FFFF, 32'd1, 4'd3, d, o, e, lat);
    check("t2_add_data", d, 32'h8000_0000);
    check("t2_add_ovf", 32'(o), 32'd1);
    check("t2_add_lat", 32'(lat), 32'd3);
    run_op(0, 32'h8000_0000, 32'd1, 4'd4, d, o, e, lat);
    check("t2_sub_data", d, 32'h7FFF_FFFF);
    check("t2_sub_ovf", 32'(o), 32'd1);
    run_op(0, 32'd5, 32'd3, 4'd4, d, o, e, lat);
    check("t2_sub2_data", d, 32'd2);
    check("t2_sub2_ovf", 32'(o), 32'd0);
    run_op(3, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2, d, o, e, lat);
    check("t2_xor_data", d, 32'h0FF0_0FF0);
    run_op(3, 32'h0000_FFFF, 32'h00FF_0000, 4'd1, d, o, e, lat);
    check("t2_or_data", d, 32'h00FF_FFFF);
    check("t2_or_err", 32'(e), 32'd0);

    // 3: fairness with all requesters pending (last grant was 3).
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h1000_0000 + i, 32'h0000_00F0 + i, 4'(i));
    ng = 0;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        gid[ng]  = oh_to_int(req_ready);
        gcyc[ng] = c;
        ng++;
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    check("t3_grant_count", 32'(ng), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t3_order%0d", k), 32'(gid[k]), 32'(k % NREQ));
      if (k > 0) check($sformatf("t3_gap%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'd4);
    end
    wait_rsp_done(0);

    // 4: illegal op; ALU drive keeps the last legal op (requester 0's).
    run_op(2, 32'hDEAD, 32'hBEEF, 4'd7, d, o, e, lat);
    check("t4_lat", 32'(lat), 32'd1);
    check("t4_err", 32'(e), 32'd1);
    check("t4_data", d, 32'd0);
    check("t4_ovf", 32'(o), 32'd0);
    check("t4_alu_a", alu_a, 32'h1000_0000);
    check("t4_alu_b", alu_b, 32'h0000_00F0);
    check("t4_alu_sel", 32'(alu_sel), 32'd0);

    // 5: response backpressure with another requester waiting.
    rsp_ready = '0;
    set_req(1, 32'd10, 32'd20, 4'd3);
    wait_grant(1);
    set_req(0, 32'hAAAA_5555, 32'h0F0F_0F0F, 4'd0);
    for (int c = 0; c < 30 && rsp_valid == '0; c++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("t5_rsp_valid", 32'(rsp_valid), 32'h2);
      check("t5_data", rsp_data, 32'd30);
      check("t5_ovf", 32'(rsp_ovf), 32'd0);
      check("t5_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = '1;
    check("t5_still_valid", 32'(rsp_valid), 32'h2);
    @(negedge clk);
    check("t5_released", 32'(rsp_valid), 32'd0);
    check("t5_next_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp_done(0);
    check("t5_and_data", rsp_data, 32'h0A0A_0505);

    // 6: reset asserted during WAIT.
    set_req(2, 32'd1, 32'd2, 4'd3);
    wait_grant(2);
    @(posedge clk); #1;
    set_req(0, 32'd7, 32'd9, 4'd3);
    set_req(3, 32'd4, 32'd4, 4'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_alu_a", alu_a, 32'd0);
    check("t6_alu_b", alu_b, 32'd0);
    check("t6_alu_sel", 32'(alu_sel), 32'd0);
    check("t6_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_first_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp_done(0);
    check("t6_data0", rsp_data, 32'd16);
    wait_grant(3);
    wait_rsp_done(3);
    check("t6_data3", rsp_data, 32'd4);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
